ntt_stage_seq: RTL and testbench

- Parametrised address/control sequencer for an in-place radix-2 iterative NTT. It succeeds the fixed-size address generator.
- Drives the read addresses, twiddle ROM address and delayed write addresses for a dual-buffer (ping-pong) RAM pair around the butterfly pipeline.
- Supports configurable transform size, configurable butterfly latency, forward/inverse twiddle selection and issue stalling.
- Sits between the top-level start/done control and the RAM banks, twiddle ROM and butterfly datapath.

---
 rtl/ntt_stage_seq_if.sv | 34 +++
 rtl/ntt_stage_seq.sv | 148 ++++++++++++++
 tb/tb_ntt_stage_seq.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_seq_if.sv
// Handshake and address bus between the NTT stage sequencer and its
// surroundings (start/done control, RAM banks, twiddle ROM, butterfly).
interface ntt_stage_seq_if #(
    parameter int LOGN = 8
);
    logic            start;
    logic            inverse;
    logic            hold;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic            rd_buf;
    logic [LOGN-1:0] rd_addr_x;
    logic [LOGN-1:0] rd_addr_y;
    logic [LOGN-1:0] tw_addr;
    logic            bf_en;
    logic            wr_en;
    logic            wr_buf;
    logic [LOGN-1:0] wr_addr_x;
    logic [LOGN-1:0] wr_addr_y;
    logic            out_buf;

    modport master (
        output start, inverse, hold,
        input  busy, done, rd_en, rd_buf, rd_addr_x, rd_addr_y, tw_addr,
               bf_en, wr_en, wr_buf, wr_addr_x, wr_addr_y, out_buf
    );

    modport slave (
        input  start, inverse, hold,
        output busy, done, rd_en, rd_buf, rd_addr_x, rd_addr_y, tw_addr,
               bf_en, wr_en, wr_buf, wr_addr_x, wr_addr_y, out_buf
    );
endinterface

// File: rtl/ntt_stage_seq.sv
// Address/control sequencer for an in-place radix-2 iterative NTT over a
// ping-pong RAM pair. Issues one butterfly per cycle, then waits for the
// butterfly pipeline to drain before the next stage.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing butterfly k of stage s (stalled while hold=1)
// DRAIN | counting down the write delay before next stage or done
module ntt_stage_seq #(
    parameter int LOGN   = 8,
    parameter int BF_LAT = 4,
    parameter int RD_LAT = 1
) (
    input logic           clk,
    input logic           reset,
    ntt_stage_seq_if.slave bus
);
    localparam int D   = BF_LAT + RD_LAT;
    localparam int KW  = LOGN - 1;
    localparam int DLW = 2 * LOGN + 2;

    localparam logic [KW-1:0]   K_LAST = {KW{1'b1}};
    localparam logic [3:0]      S_LAST = 4'(LOGN - 1);
    localparam logic [4:0]      D_CNT  = 5'(D);
    localparam logic [LOGN-1:0] ONE    = LOGN'(1);
    localparam logic [31:0]     LOGN_V = LOGN;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state;
    logic [3:0]      stage;
    logic [KW-1:0]   k;
    logic [4:0]      cnt;
    logic            mode;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_x;
    logic [LOGN-1:0] rd_addr_y;
    logic [LOGN-1:0] tw_addr;
    logic [DLW-1:0]  dline [D];
    logic [RD_LAT-1:0] bf_line;

    logic [LOGN-1:0] kx, half, p, g, a, b;
    logic [LOGN-2:0] twi;

    // Butterfly addresses and twiddle index for the current (stage, k).
    always_comb begin
        kx   = {1'b0, k};
        half = ONE << stage;
        p    = kx & (half - ONE);
        g    = kx >> stage;
        a    = ((g << stage) << 1) | p;
        b    = a | half;
        twi  = p[LOGN-2:0] << (S_LAST - stage);
    end

    // Stage/issue/drain control with registered read-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            cnt       <= '0;
            mode      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_x <= '0;
            rd_addr_y <= '0;
            tw_addr   <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mode  <= bus.inverse;
                        stage <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.hold) begin
                        rd_en     <= 1'b1;
                        rd_addr_x <= a;
                        rd_addr_y <= b;
                        tw_addr   <= {mode, twi};
                        if (k == K_LAST) begin
                            cnt   <= D_CNT;
                            state <= DRAIN;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Last stage waits one extra cycle so done lands after its final write.
                    if (stage == S_LAST) begin
                        if (cnt == 5'd0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end else if (cnt == 5'd1) begin
                        cnt   <= '0;
                        stage <= stage + 1'b1;
                        k     <= '0;
                        state <= ISSUE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-side and butterfly-valid delay lines; advance every cycle, hold or not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) dline[i] <= '0;
            bf_line <= '0;
        end else begin
            dline[0] <= {rd_en, ~stage[0], rd_addr_x, rd_addr_y};
            for (int i = 1; i < D; i++) dline[i] <= dline[i-1];
            bf_line[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) bf_line[i] <= bf_line[i-1];
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.rd_en     = rd_en;
    assign bus.rd_buf    = stage[0];
    assign bus.rd_addr_x = rd_addr_x;
    assign bus.rd_addr_y = rd_addr_y;
    assign bus.tw_addr   = tw_addr;
    assign bus.bf_en     = bf_line[RD_LAT-1];
    assign {bus.wr_en, bus.wr_buf, bus.wr_addr_x, bus.wr_addr_y} = dline[D-1];
    assign bus.out_buf   = LOGN_V[0];
endmodule

// File: tb/tb_ntt_stage_seq.sv
// Self-checking bench for ntt_stage_seq: small configuration checked cycle by
// cycle against a schedule model, default configuration checked for timing.
module tb_ntt_stage_seq;
    localparam int LS  = 3;
    localparam int NS  = 8;
    localparam int DS  = 3;
    localparam int MAXC = 260;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    bit exp_en  [MAXC];
    int exp_a   [MAXC];
    int exp_b   [MAXC];
    int exp_tw  [MAXC];
    int exp_buf [MAXC];
    bit hold_pat[MAXC];
    int done_c;

    ntt_stage_seq_if #(.LOGN(LS)) bs ();
    ntt_stage_seq_if #(.LOGN(8))  bd ();

    ntt_stage_seq #(.LOGN(LS), .BF_LAT(2), .RD_LAT(1)) dut_s (
        .clk(clk), .reset(reset), .bus(bs)
    );
    ntt_stage_seq dut_d (
        .clk(clk), .reset(reset), .bus(bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Schedule of every butterfly: cycle, pair and twiddle, honouring hold.
    task automatic build_model(input bit inv);
        int c, last, half;
        for (int i = 0; i < MAXC; i++) begin
            exp_en[i] = 0; exp_a[i] = 0; exp_b[i] = 0; exp_tw[i] = 0; exp_buf[i] = 0;
        end
        c = 1;
        last = 0;
        for (int s = 0; s < LS; s++) begin
            half = 2 ** s;
            for (int blk = 0; blk < NS / (2 * half); blk++) begin
                for (int p = 0; p < half; p++) begin
                    while (hold_pat[c]) c++;
                    exp_en[c]  = 1;
                    exp_a[c]   = blk * 2 * half + p;
                    exp_b[c]   = blk * 2 * half + p + half;
                    exp_tw[c]  = int'(inv) * (NS / 2) + p * (2 ** (LS - 1 - s));
                    exp_buf[c] = s % 2;
                    last = c;
                    c++;
                end
            end
            c = last + DS + 1;
        end
        done_c = c;
    endtask

    task automatic run_small(input bit inv, input int abort_at, output int obs_done);
        obs_done = -1;
        @(negedge clk);
        bs.start = 1'b1; bs.inverse = inv; bs.hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bs.start = 1'b0; bs.inverse = ~inv;
        for (int c = 0; c <= done_c + 2; c++) begin
            if (c == abort_at) break;
            bs.hold = hold_pat[c+1];
            if (bs.done === 1'b1 && obs_done < 0) obs_done = c;
            chk($sformatf("rd_en@%0d", c), bs.rd_en, exp_en[c]);
            if (exp_en[c]) begin
                chk($sformatf("rd_x@%0d", c), bs.rd_addr_x, exp_a[c]);
                chk($sformatf("rd_y@%0d", c), bs.rd_addr_y, exp_b[c]);
                chk($sformatf("tw@%0d", c), bs.tw_addr, exp_tw[c]);
                chk($sformatf("rd_buf@%0d", c), bs.rd_buf, exp_buf[c]);
            end
            chk($sformatf("bf_en@%0d", c), bs.bf_en, (c >= 1) ? int'(exp_en[c-1]) : 0);
            if (c >= DS) begin
                chk($sformatf("wr_en@%0d", c), bs.wr_en, exp_en[c-DS]);
                if (exp_en[c-DS]) begin
                    chk($sformatf("wr_x@%0d", c), bs.wr_addr_x, exp_a[c-DS]);
                    chk($sformatf("wr_y@%0d", c), bs.wr_addr_y, exp_b[c-DS]);
                    chk($sformatf("wr_buf@%0d", c), bs.wr_buf, 1 - exp_buf[c-DS]);
                end
            end else begin
                chk($sformatf("wr_en@%0d", c), bs.wr_en, 0);
            end
            chk($sformatf("done@%0d", c), bs.done, (c == done_c) ? 1 : 0);
            chk($sformatf("busy@%0d", c), bs.busy, (c < done_c) ? 1 : 0);
            @(negedge clk);
        end
        bs.hold = 1'b0;
    endtask

    initial begin
        int od, nd, rdc, dfirst;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bs.start = 0; bs.inverse = 0; bs.hold = 0;
        bd.start = 0; bd.inverse = 0; bd.hold = 0;
        for (int i = 0; i < MAXC; i++) hold_pat[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst_rd_en", bs.rd_en, 0);
        chk("rst_busy", bs.busy, 0);
        chk("rst_done", bs.done, 0);
        chk("rst_wr_en", bs.wr_en, 0);
        chk("rst_tw", bs.tw_addr, 0);
        chk("out_buf_small", bs.out_buf, 1);
        chk("out_buf_dflt", bd.out_buf, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: forward, no hold.
        build_model(1'b0);
        run_small(1'b0, -1, od);
        chk("done_cycle_fwd", od, 22);

        // Directed: inverse, no hold.
        build_model(1'b1);
        run_small(1'b1, -1, od);
        chk("done_cycle_inv", od, 22);

        // Directed: hold sampled in cycles 2..3 of stage 0.
        hold_pat[2] = 1; hold_pat[3] = 1;
        build_model(1'b0);
        run_small(1'b0, -1, od);
        chk("done_cycle_hold", od, 24);

        // Randomized hold patterns and mode.
        for (int r = 0; r < 4; r++) begin
            bit inv;
            for (int i = 0; i < MAXC; i++) hold_pat[i] = (i >= 1 && i <= 60) ? ($urandom_range(3) == 0) : 1'b0;
            inv = 1'($urandom_range(1));
            build_model(inv);
            run_small(inv, -1, od);
        end

        // Reset mid-run at cycle 10, then a clean run.
        for (int i = 0; i < MAXC; i++) hold_pat[i] = 0;
        build_model(1'b0);
        run_small(1'b0, 10, od);
        reset = 1'b0;
        #1;
        chk("mid_rst_rd_en", bs.rd_en, 0);
        chk("mid_rst_busy", bs.busy, 0);
        chk("mid_rst_done", bs.done, 0);
        chk("mid_rst_rd_x", bs.rd_addr_x, 0);
        chk("mid_rst_rd_y", bs.rd_addr_y, 0);
        chk("mid_rst_tw", bs.tw_addr, 0);
        chk("mid_rst_rd_buf", bs.rd_buf, 0);
        chk("mid_rst_bf_en", bs.bf_en, 0);
        chk("mid_rst_wr_en", bs.wr_en, 0);
        chk("mid_rst_wr_buf", bs.wr_buf, 0);
        chk("mid_rst_wr_x", bs.wr_addr_x, 0);
        chk("mid_rst_wr_y", bs.wr_addr_y, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_small(1'b0, -1, od);
        chk("done_cycle_after_rst", od, 22);

        // Default configuration with a start pulse while busy.
        nd = 0; rdc = 0; dfirst = -1;
        @(negedge clk);
        bd.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bd.start = 1'b0;
        for (int c = 0; c <= 1100; c++) begin
            if (c == 4) bd.start = 1'b1;
            if (c == 5) begin
                bd.start = 1'b0;
                chk("dflt_busy@5", bd.busy, 1);
            end
            if (bd.done === 1'b1) begin
                nd++;
                if (dfirst < 0) dfirst = c;
            end
            if (bd.rd_en === 1'b1) rdc++;
            @(negedge clk);
        end
        chk("dflt_done_cycle", dfirst, 1065);
        chk("dflt_done_count", nd, 1);
        chk("dflt_rd_count", rdc, 1024);
        chk("dflt_idle_busy", bd.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
